// File: rtl/xsm_capture_sched.sv
// xsm_capture_sched: merges periodic/software/external triggers, scans enabled ADC channels
// in ascending order and queues timestamped records. `XSM_SCHED_EXT_TRIG_SYNC_EN adds an ext_trigger synchronizer.
module xsm_capture_sched #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_en,
  input  logic [7:0]                cfg_ch_mask,
  input  logic [PERIOD_WIDTH-1:0]   cfg_period,
  input  logic                      sw_trigger,
  input  logic                      ext_trigger,
  input  logic [8*SAMPLE_WIDTH-1:0] adc_flat,
  output logic                      rec_valid,
  input  logic                      rec_ready,
  output logic [SAMPLE_WIDTH-1:0]   rec_data,
  output logic [2:0]                rec_ch,
  output logic [47:0]               rec_ts,
  output logic                      busy,
  output logic                      trig_miss,
  output logic                      fifo_ovf,
  input  logic                      status_clr
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int RW = SAMPLE_WIDTH + 3 + 48;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [47:0] ts_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_reg <= '0;
    else        ts_reg <= ts_reg + 48'd1;
  end

  logic ext_in;
`ifdef XSM_SCHED_EXT_TRIG_SYNC_EN
  logic [1:0] ext_sync_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ext_sync_reg <= '0;
    else        ext_sync_reg <= {ext_sync_reg[0], ext_trigger};
  end
  assign ext_in = ext_sync_reg[1];
`else
  assign ext_in = ext_trigger;
`endif

  logic ext_d_reg, ext_d2_reg, ext_rise;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_d_reg  <= 1'b0;
      ext_d2_reg <= 1'b0;
    end else begin
      ext_d_reg  <= ext_in;
      ext_d2_reg <= ext_d_reg;
    end
  end
  assign ext_rise = ext_d_reg & ~ext_d2_reg;

  // Down-counter parked at its load value whenever the periodic source is off.
  logic [PERIOD_WIDTH-1:0] timer_reg;
  logic timer_run, tick;
  assign timer_run = cfg_en && (cfg_period != '0);
  assign tick      = timer_run && (timer_reg == '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  timer_reg <= '0;
    else if (!timer_run || tick) timer_reg <= cfg_period - PERIOD_WIDTH'(1);
    else                         timer_reg <= timer_reg - PERIOD_WIDTH'(1);
  end

  logic trig;
  assign trig = sw_trigger | ext_rise | tick;

  logic [SAMPLE_WIDTH-1:0] adc_ch [8];
  for (genvar gi = 0; gi < 8; gi++) begin : g_ch
    assign adc_ch[gi] = adc_flat[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
  end

  logic [0:0]  state_reg;
  logic [7:0]  mask_reg, mask_next;
  logic [47:0] scan_ts_reg;
  logic [2:0]  low_idx;
  logic        push;

  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_reg[i]) low_idx = 3'(i);
    end
  end
  assign mask_next = mask_reg & ~(8'd1 << low_idx);
  // An aborting cycle (cfg_en low in SCAN) captures nothing.
  assign push = (state_reg == SCAN) && cfg_en;
  assign busy = (state_reg == SCAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      mask_reg    <= '0;
      scan_ts_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (trig && cfg_en && (cfg_ch_mask != 8'd0)) begin
        state_reg   <= SCAN;
        mask_reg    <= cfg_ch_mask;
        scan_ts_reg <= ts_reg;
      end
    end else if (!cfg_en) begin
      state_reg <= IDLE;
      mask_reg  <= '0;
    end else begin
      mask_reg <= mask_next;
      if (mask_next == 8'd0) state_reg <= IDLE;
    end
  end

  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          full, pop, wr_en, drop;
  logic [RW-1:0] head;

  assign full  = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign pop   = rec_valid && rec_ready;
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= {adc_ch[low_idx], low_idx, scan_ts_reg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= (wr_ptr_reg == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
      if (pop)   rd_ptr_reg <= (rd_ptr_reg == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + AW'(1);
      if (wr_en && !pop)      count_reg <= count_reg + (AW+1)'(1);
      else if (!wr_en && pop) count_reg <= count_reg - (AW+1)'(1);
    end
  end

  // Head fields read as zero while empty so outputs match their reset values.
  assign rec_valid = (count_reg != '0);
  assign head      = mem[rd_ptr_reg];
  assign rec_data  = rec_valid ? head[RW-1 -: SAMPLE_WIDTH] : '0;
  assign rec_ch    = rec_valid ? head[50:48] : 3'd0;
  assign rec_ts    = rec_valid ? head[47:0] : 48'd0;

  logic trig_miss_reg, fifo_ovf_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_miss_reg <= 1'b0;
      fifo_ovf_reg  <= 1'b0;
    end else begin
      trig_miss_reg <= status_clr ? 1'b0 : (trig_miss_reg | (busy && trig));
      fifo_ovf_reg  <= status_clr ? 1'b0 : (fifo_ovf_reg | drop);
    end
  end
  assign trig_miss = trig_miss_reg;
  assign fifo_ovf  = fifo_ovf_reg;

endmodule

// File: tb/tb_xsm_capture_sched.sv
// Bench for xsm_capture_sched: queue-based reference model checked every cycle, plus directed
// scenarios with hand-computed expectations on the observed record/busy streams.
`timescale 1ns/1ps
module tb_xsm_capture_sched;
  localparam int SW    = 16;
  localparam int DEPTH = 8;
  localparam int PW    = 24;
`ifdef XSM_SCHED_EXT_TRIG_SYNC_EN
  localparam int EXT_LAT = 3;
`else
  localparam int EXT_LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_en = 1'b0;
  logic [7:0] cfg_ch_mask = 8'd0;
  logic [PW-1:0] cfg_period = '0;
  logic sw_trigger = 1'b0;
  logic ext_trigger = 1'b0;
  logic [8*SW-1:0] adc_flat = '0;
  logic rec_ready = 1'b0;
  logic status_clr = 1'b0;
  logic rec_valid, busy, trig_miss, fifo_ovf;
  logic [SW-1:0] rec_data;
  logic [2:0] rec_ch;
  logic [47:0] rec_ts;

  xsm_capture_sched #(.SAMPLE_WIDTH(SW), .FIFO_DEPTH(DEPTH), .PERIOD_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_ch_mask(cfg_ch_mask),
    .cfg_period(cfg_period), .sw_trigger(sw_trigger), .ext_trigger(ext_trigger),
    .adc_flat(adc_flat), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_data(rec_data), .rec_ch(rec_ch), .rec_ts(rec_ts), .busy(busy),
    .trig_miss(trig_miss), .fifo_ovf(fifo_ovf), .status_clr(status_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  ch;
    logic [47:0] ts;
  } rec_t;

  // Reference model: state as seen during the current cycle.
  rec_t        m_fifo[$];
  int          m_chans[$];
  logic [47:0] m_ts, m_scan_ts;
  logic        m_miss, m_ovf;
  int          m_run;
  logic        ext_h[5];

  rec_t        log_q[$];
  logic [47:0] busy_log[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (model ts %0d)", name, act, exp, m_ts);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_chans.delete();
    m_ts = '0;
    m_scan_ts = '0;
    m_miss = 1'b0;
    m_ovf = 1'b0;
    m_run = 0;
    for (int i = 0; i < 5; i++) ext_h[i] = 1'b0;
  endtask

  task automatic model_advance();
    logic running, tick, trig, pop, push, full_before, miss_set, ovf_set;
    rec_t r;
    int ch;
    running = cfg_en && (cfg_period != '0);
    if (running) m_run++; else m_run = 0;
    tick = running && ((m_run % int'(cfg_period)) == 0);
    trig = sw_trigger || tick || (ext_h[EXT_LAT-1] && !ext_h[EXT_LAT]);
    pop = (m_fifo.size() != 0) && rec_ready;
    push = 1'b0;
    miss_set = 1'b0;
    ovf_set = 1'b0;
    r = '0;
    if (m_chans.size() == 0) begin
      if (trig && cfg_en && cfg_ch_mask != 8'd0) begin
        for (int i = 0; i < 8; i++) if (cfg_ch_mask[i]) m_chans.push_back(i);
        m_scan_ts = m_ts;
      end
    end else begin
      if (trig) miss_set = 1'b1;
      if (!cfg_en) m_chans.delete();
      else begin
        ch = m_chans.pop_front();
        r.data = adc_flat[ch*SW +: SW];
        r.ch = 3'(ch);
        r.ts = m_scan_ts;
        push = 1'b1;
      end
    end
    full_before = (m_fifo.size() == DEPTH);
    if (pop) void'(m_fifo.pop_front());
    if (push) begin
      if (full_before && !pop) ovf_set = 1'b1;
      else m_fifo.push_back(r);
    end
    m_miss = status_clr ? 1'b0 : (m_miss | miss_set);
    m_ovf  = status_clr ? 1'b0 : (m_ovf | ovf_set);
    for (int i = 4; i > 0; i--) ext_h[i] = ext_h[i-1];
    ext_h[0] = ext_trigger;
    m_ts = m_ts + 48'd1;
  endtask

  // Single compare process: outputs checked on the falling edge, then the model steps.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_valid", 64'(rec_valid), 64'd0);
        chk("rst_data", 64'(rec_data), 64'd0);
        chk("rst_ch", 64'(rec_ch), 64'd0);
        chk("rst_ts", 64'(rec_ts), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_miss", 64'(trig_miss), 64'd0);
        chk("rst_ovf", 64'(fifo_ovf), 64'd0);
        model_reset();
      end else begin
        chk("rec_valid", 64'(rec_valid), 64'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) begin
          chk("rec_data", 64'(rec_data), 64'(m_fifo[0].data));
          chk("rec_ch", 64'(rec_ch), 64'(m_fifo[0].ch));
          chk("rec_ts", 64'(rec_ts), 64'(m_fifo[0].ts));
        end
        chk("busy", 64'(busy), 64'(m_chans.size() != 0));
        chk("trig_miss", 64'(trig_miss), 64'(m_miss));
        chk("fifo_ovf", 64'(fifo_ovf), 64'(m_ovf));
        if (rec_valid && rec_ready) log_q.push_back({rec_data, rec_ch, rec_ts});
        if (busy) busy_log.push_back(m_ts);
        model_advance();
      end
    end
  end

  // ADC pattern: channel i reads 16'hA000 | i<<8 | low byte of the cycle's timestamp.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) adc_flat[i*SW +: SW] = {4'hA, 1'b0, 3'(i), m_ts[7:0]};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_sw();
    sw_trigger = 1'b1;
    cyc(1);
    sw_trigger = 1'b0;
  endtask

  task automatic clear_logs();
    log_q.delete();
    busy_log.delete();
  endtask

  initial begin
    int exp1[4];
    logic [47:0] t0, s0;
    int guard;
    exp1 = '{0, 2, 5, 7};

    cyc(3);
    rst_n = 1'b1;
    cfg_en = 1'b1;
    cfg_ch_mask = 8'hA5;
    rec_ready = 1'b1;

    // Scenario 1: mask A5, software trigger at ts=10.
    guard = 0;
    while (m_ts != 48'd10 && guard < 50) begin cyc(1); guard++; end
    chk("t1_reach_ts10", 64'(m_ts), 64'd10);
    clear_logs();
    pulse_sw();
    cyc(10);
    chk("t1_rec_count", 64'(log_q.size()), 64'd4);
    if (log_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("t1_ch", 64'(log_q[i].ch), 64'(exp1[i]));
        chk("t1_ts", 64'(log_q[i].ts), 64'd10);
      end
      chk("t1_data_ch2", 64'(log_q[1].data), 64'h0000_0000_0000_A20C);
      chk("t1_data_ch7", 64'(log_q[3].data), 64'h0000_0000_0000_A70E);
    end
    chk("t1_busy_len", 64'(busy_log.size()), 64'd4);
    if (busy_log.size() == 4) begin
      chk("t1_busy_first", 64'(busy_log[0]), 64'd11);
      chk("t1_busy_last", 64'(busy_log[3]), 64'd14);
    end

    // Scenario 2: periodic trigger every 5 cycles, then disabled via period 0.
    cfg_en = 1'b0;
    cfg_period = 24'd5;
    cfg_ch_mask = 8'h01;
    cyc(2);
    clear_logs();
    cfg_en = 1'b1;
    s0 = m_ts;
    cyc(26);
    chk("t2_scans", 64'(busy_log.size()), 64'd5);
    if (busy_log.size() == 5) begin
      chk("t2_first_scan", 64'(busy_log[0]), 64'(s0 + 48'd5));
      for (int i = 1; i < 5; i++) chk("t2_spacing", 64'(busy_log[i] - busy_log[i-1]), 64'd5);
    end
    cfg_period = '0;
    busy_log.delete();
    cyc(20);
    chk("t2_no_more_scans", 64'(busy_log.size()), 64'd0);
    chk("t2_records", 64'(log_q.size()), 64'd5);

    // Scenario 3: FIFO overflow with downstream stalled, then status clear and drain.
    rec_ready = 1'b0;
    cfg_ch_mask = 8'hFF;
    clear_logs();
    t0 = m_ts;
    pulse_sw();
    cyc(9);
    pulse_sw();
    cyc(12);
    chk("t3_ovf_set", 64'(fifo_ovf), 64'd1);
    chk("t3_head_valid", 64'(rec_valid), 64'd1);
    chk("t3_head_ts", 64'(rec_ts), 64'(t0));
    chk("t3_no_miss", 64'(trig_miss), 64'd0);
    status_clr = 1'b1;
    cyc(1);
    status_clr = 1'b0;
    chk("t3_ovf_cleared", 64'(fifo_ovf), 64'd0);
    rec_ready = 1'b1;
    guard = 0;
    while (log_q.size() < 8 && guard < 30) begin cyc(1); guard++; end
    cyc(2);
    chk("t3_drained", 64'(log_q.size()), 64'd8);
    if (log_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t3_ch", 64'(log_q[i].ch), 64'(i));
        chk("t3_ts", 64'(log_q[i].ts), 64'(t0));
      end
    end
    chk("t3_empty", 64'(rec_valid), 64'd0);

    // Scenario 4: external edge arriving mid-scan is dropped and flagged.
    clear_logs();
    pulse_sw();
    cyc(2);
    ext_trigger = 1'b1;
    cyc(12);
    ext_trigger = 1'b0;
    cyc(6);
    chk("t4_miss", 64'(trig_miss), 64'd1);
    chk("t4_records", 64'(log_q.size()), 64'd8);
    status_clr = 1'b1;
    cyc(1);
    status_clr = 1'b0;
    chk("t4_miss_cleared", 64'(trig_miss), 64'd0);

    // Scenario 5: cfg_en dropped after the third push aborts the scan.
    clear_logs();
    pulse_sw();
    cyc(3);
    cfg_en = 1'b0;
    cyc(1);
    cyc(5);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_records", 64'(log_q.size()), 64'd3);
    if (log_q.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("t5_ch", 64'(log_q[i].ch), 64'(i));
    end
    chk("t5_busy_cycles", 64'(busy_log.size()), 64'd4);
    cfg_en = 1'b1;

    // Scenario 6: reset mid-scan with four records queued, then a clean scan.
    rec_ready = 1'b0;
    clear_logs();
    pulse_sw();
    cyc(4);
    chk("t6_pre_valid", 64'(rec_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(rec_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_ts", 64'(rec_ts), 64'd0);
    cyc(2);
    rst_n = 1'b1;
    rec_ready = 1'b1;
    clear_logs();
    cyc(2);
    t0 = m_ts;
    pulse_sw();
    cyc(15);
    chk("t6_records", 64'(log_q.size()), 64'd8);
    if (log_q.size() == 8) begin
      chk("t6_first_ts", 64'(log_q[0].ts), 64'(t0));
      chk("t6_last_ch", 64'(log_q[7].ch), 64'd7);
    end
    chk("t6_miss", 64'(trig_miss), 64'd0);
    chk("t6_ovf", 64'(fifo_ovf), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
